// File: rtl/cdc_hs_tx.sv
// Source-domain side of a 4-phase req/ack bundled-data clock-domain crossing.
// Optional watchdog flag enabled by defining CDC_HS_TX_TIMEOUT_EN.
module cdc_hs_tx #(
    parameter int W           = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_data,
    output logic         cdc_req,
    output logic [W-1:0] cdc_data,
    input  logic         cdc_ack
`ifdef CDC_HS_TX_TIMEOUT_EN
    ,
    output logic         err_timeout
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                 state_r;
    logic                   req_r;
    logic [W-1:0]           data_r;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   ack_s;
    logic                   in_rdy_s;
    logic                   state_chg_s;

    assign ack_s    = sync_r[SYNC_STAGES-1];
    assign in_rdy_s = (state_r == ST_IDLE) && !ack_s;
    assign in_rdy   = in_rdy_s;
    assign cdc_req  = req_r;
    assign cdc_data = data_r;

    // Plain flop chain for the asynchronous acknowledge; cdc_ack feeds the first flop directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], cdc_ack};
        end
    end

    // Handshake FSM; payload and request are only ever loaded on acceptance in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            data_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_vld && in_rdy_s) begin
                        data_r  <= in_data;
                        req_r   <= 1'b1;
                        state_r <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack_s) begin
                        req_r   <= 1'b0;
                        state_r <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!ack_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    req_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Flags the cycles in which the FSM takes a transition.
    always_comb begin
        state_chg_s = 1'b0;
        case (state_r)
            ST_IDLE: state_chg_s = in_vld && in_rdy_s;
            ST_REQ:  state_chg_s = ack_s;
            ST_ACK:  state_chg_s = !ack_s;
            default: state_chg_s = 1'b1;
        endcase
    end

`ifdef CDC_HS_TX_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          err_r;

    assign err_timeout = err_r;

    // Per-state dwell counter; saturates so the flag can never be missed.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (state_chg_s) begin
            cnt_nxt_s = '0;
        end else if ((state_r != ST_IDLE) && (cnt_r != TO_MAX)) begin
            cnt_nxt_s = cnt_r + CW'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter and sticky flag; the flag only observes, it never aborts the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            err_r <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            if (cnt_nxt_s == TO_MAX) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end
`else
    logic unused_s;
    assign unused_s = state_chg_s;
`endif

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed self-checking bench for cdc_hs_tx; the bench plays the far-domain responder.
// Define CDC_HS_TX_TIMEOUT_EN to also exercise the watchdog with TIMEOUT=16.
module tb_cdc_hs_tx;
    localparam int W = 32;
    localparam int S = 2;
`ifdef CDC_HS_TX_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_vld;
    logic         in_rdy;
    logic [W-1:0] in_data;
    logic         cdc_req;
    logic [W-1:0] cdc_data;
    logic         cdc_ack;
`ifdef CDC_HS_TX_TIMEOUT_EN
    logic         err_timeout;
`endif

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic prev_req = 1'b0;

    cdc_hs_tx #(.W(W), .SYNC_STAGES(S), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
        .in_data(in_data), .cdc_req(cdc_req), .cdc_data(cdc_data),
        .cdc_ack(cdc_ack)
`ifdef CDC_HS_TX_TIMEOUT_EN
        , .err_timeout(err_timeout)
`endif
    );

    always #5 clk = ~clk;

    // Payload may only change in the cycle a new request rises.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (cdc_data !== prev_data && !(cdc_req === 1'b1 && prev_req === 1'b0)) begin
                errors++;
                $display("FAIL data_stable: cdc_data=%h changed from %h without a new request", cdc_data, prev_data);
            end
        end
        prev_data = cdc_data;
        prev_req  = cdc_req;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
        $fatal(1);
    end

    task automatic wait_rdy();
        int n = 0;
        while (in_rdy !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL wait_rdy: in_rdy=%b after %0d cycles, expected 1", in_rdy, n);
        end
    endtask

    task automatic wait_req_low();
        int n = 0;
        while (cdc_req !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cdc_req !== 1'b0) begin
            errors++;
            $display("FAIL wait_req_low: cdc_req=%b after %0d cycles, expected 0", cdc_req, n);
        end
    endtask

    task automatic finish_hs();
        cdc_ack = 1'b1;
        wait_req_low();
        cdc_ack = 1'b0;
        wait_rdy();
    endtask

    task automatic offer(input logic [W-1:0] word);
        in_vld  = 1'b1;
        in_data = word;
        @(negedge clk);
        in_vld  = 1'b0;
        in_data = '0;
        checks++;
        if (cdc_req !== 1'b1 || cdc_data !== word) begin
            errors++;
            $display("FAIL accept: req=%b data=%h, expected req=1 data=%h", cdc_req, cdc_data, word);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_vld = 1'b0; in_data = '0; cdc_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cdc_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", cdc_req); end
        checks++;
        if (cdc_data !== 32'h0000_0000) begin errors++; $display("FAIL reset_data: got %h expected 0", cdc_data); end
        checks++;
        if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", in_rdy); end
`ifdef CDC_HS_TX_TIMEOUT_EN
        checks++;
        if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_timeout); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic test_latency();
        offer(32'hDEAD_BEEF);
        repeat (4) @(negedge clk);
        checks++;
        if (cdc_req !== 1'b1) begin errors++; $display("FAIL req_hold: got %b expected 1", cdc_req); end
        cdc_ack = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (cdc_req !== (k < 3)) begin
                errors++;
                $display("FAIL req_fall_edge%0d: got %b expected %b", k, cdc_req, (k < 3));
            end
        end
        repeat (3) @(negedge clk);
        cdc_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b0) begin errors++; $display("FAIL rdy_early: got %b expected 0", in_rdy); end
        repeat (2) @(negedge clk);
        checks++;
        if (in_rdy !== 1'b1) begin errors++; $display("FAIL rdy_return: got %b expected 1", in_rdy); end
        checks++;
        if (cdc_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL data_held: got %h expected deadbeef", cdc_data); end
    endtask

    task automatic test_random();
        logic [W-1:0] word;
        for (int i = 0; i < 100; i++) begin
            word = $urandom;
            wait_rdy();
            offer(word);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            checks++;
            if (cdc_req !== 1'b1 || cdc_data !== word) begin
                errors++;
                $display("FAIL rand_word%0d: req=%b data=%h, expected req=1 data=%h", i, cdc_req, cdc_data, word);
            end
            cdc_ack = 1'b1;
            wait_req_low();
            repeat ($urandom_range(0, 20)) @(negedge clk);
            cdc_ack = 1'b0;
        end
        wait_rdy();
    endtask

    task automatic test_hold();
        int cyc = 0;
        bit released = 1'b0;
        wait_rdy();
        offer(32'hA5A5_0001);
        in_vld = 1'b1;
        while (cyc < 40) begin
            if (released && in_rdy === 1'b1) break;
            in_data = $urandom;
            if (cyc == 3) cdc_ack = 1'b1;
            if (cdc_ack && cdc_req === 1'b0) begin cdc_ack = 1'b0; released = 1'b1; end
            @(negedge clk);
            cyc++;
            checks++;
            if (cdc_data !== 32'hA5A5_0001) begin
                errors++;
                $display("FAIL hold_data: got %h expected a5a50001", cdc_data);
            end
        end
        in_vld = 1'b0;
        checks++;
        if (!released || in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL hold_done: released=%b in_rdy=%b, expected 1 and 1", released, in_rdy);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        wait_rdy();
        offer(32'h1111_2222);
        cdc_ack = 1'b1;
        wait_req_low();
        cdc_ack = 1'b0;
        in_vld  = 1'b1;
        in_data = 32'h3333_4444;
        while (in_rdy !== 1'b1 && n < 64) begin @(negedge clk); n++; end
        @(negedge clk);
        in_vld = 1'b0;
        checks++;
        if (cdc_req !== 1'b1 || cdc_data !== 32'h3333_4444) begin
            errors++;
            $display("FAIL back_to_back: req=%b data=%h, expected req=1 data=33334444", cdc_req, cdc_data);
        end
        finish_hs();
    endtask

    task automatic test_reset_midop();
        wait_rdy();
        offer(32'h1234_5678);
        cdc_ack = 1'b1;
        @(negedge clk);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cdc_req !== 1'b0 || cdc_data !== 32'h0000_0000) begin
            errors++;
            $display("FAIL midop_reset: req=%b data=%h, expected req=0 data=0", cdc_req, cdc_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        in_vld  = 1'b1;
        in_data = 32'hCAFE_F00D;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (in_rdy !== 1'b0 || cdc_req !== 1'b0) begin
                errors++;
                $display("FAIL stale_ack%0d: rdy=%b req=%b, expected 0 and 0", k, in_rdy, cdc_req);
            end
        end
        in_vld  = 1'b0;
        cdc_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b0) begin errors++; $display("FAIL stale_rdy_early: got %b expected 0", in_rdy); end
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b1) begin errors++; $display("FAIL stale_rdy_return: got %b expected 1", in_rdy); end
        mon_en = 1'b1;
    endtask

`ifdef CDC_HS_TX_TIMEOUT_EN
    task automatic test_timeout();
        mon_en = 1'b0;
        rst_n = 1'b0; cdc_ack = 1'b0; in_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        offer(32'h0BAD_F00D);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checks++;
            if (err_timeout !== (k == 16)) begin
                errors++;
                $display("FAIL timeout_cyc%0d: got %b expected %b", k, err_timeout, (k == 16));
            end
        end
        finish_hs();
        checks++;
        if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", err_timeout); end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_random();
        test_hold();
        test_back_to_back();
        test_reset_midop();
`ifdef CDC_HS_TX_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
